obf_lut_seq: RTL and testbench
==============================

// Module: obf_lut_seq
// PURPOSE
// Programmable, multi-bank substitution-sequence engine for the obfuscation path.
// Takes an IGU index plus key, selects a bank, and looks up a {len, base} pointer entry.
// Streams len (sub, imm) word pairs to the decode-side consumer over a valid/ready handshake.
// Replaces the fixed, ppc-addressed combinational table; both tables are reloadable at runtime.
// PARAMETERS
// IDX_W    7   IGU index width; pointer table depth per bank = 2**IDX_W
// ENT_W    16  substitution/immediate word width
// ADDR_W   7   data-table address width; data depth per bank = 2**ADDR_W
// LEN_W    4   sequence-length field width; len 0 = no substitution
// BANK_W   1   bank-select width; 2**BANK_W banks
// KEY_W    8   key width; bank = key[BANK_W-1:0]
// PORTS
// clk          in   1        clock
// rst          in   1        reset, synchronous, active-low
// req_valid    in   1        lookup request
// req_ready    out  1        request accepted when valid&&ready
// req_index    in   IDX_W    IGU index
// req_key      in   KEY_W    obfuscation key (bank select)
// out_valid    out  1        output pair valid
// out_ready    in   1        consumer accepts pair
// out_sub      out  ENT_W    substitution word
// out_imm      out  ENT_W    immediate word
// out_step     out  LEN_W    position (ppc) of pair in sequence, from 0
// out_last     out  1        final pair of sequence
// out_bypass   out  1        no entry: pass original instruction
// cfg_we       in   1        table write strobe
// cfg_ready    out  1        write accepted when cfg_we&&cfg_ready
// cfg_sel      in   1        0 = data table, 1 = pointer table
// cfg_bank     in   BANK_W   target bank
// cfg_addr     in   max(IDX_W,ADDR_W)  entry address (pointer: low IDX_W bits)
// cfg_wdata    in   max(ENT_W,LEN_W+ADDR_W)  data word or {len,base}
// BEHAVIOUR
// - Reset (rst==0 at edge): state IDLE; out_valid=0, out_last=0, out_bypass=0, out_step=0,
//   out_sub=out_imm=0; every pointer-entry valid bit cleared; data table contents not reset.
// - Pointer entry usable only if its valid bit is set (set by a pointer write); an invalid entry
//   or len==0 yields bypass.
// - FSM: IDLE -> LOOKUP -> FETCH -> EMIT; EMIT -> FETCH when step advances; EMIT -> IDLE on last.
//   IDLE: req_ready=1, cfg_ready=1; on accept, latch index and bank.
//   LOOKUP: registered pointer read; if bypass -> EMIT with bypass pair; else step=0 -> FETCH.
//   FETCH: read data[bank][base+step] and data[bank][base+step+1] (both registered).
//   EMIT: out_valid=1, outputs held stable until out_ready; on handshake:
//   last -> IDLE, else step+1 -> FETCH.
// - Latency: accept at edge N -> first out_valid after edge N+3 (bypass: edge N+2).
//   Throughput: one pair per 2 cycles with out_ready held high.
// - Bypass pair: sub=imm=0, step=0, last=1, bypass=1.
// - Address arithmetic: base+step and base+step+1 are computed modulo 2**ADDR_W (wrap, no error).
// - out_last = (step == len-1).
// - req_ready=0 and cfg_ready=0 outside IDLE. Config writes are never partially applied.
// - A write in the same cycle as a request accept is performed first; the lookup sees new data.
// - Reset mid-sequence aborts immediately: out_valid drops the next cycle, no pair lost/duplicated
//   post-reset.
// TESTING
// 1 Reset, then req index 64 key 0 -> after 2 cycles: out_valid, bypass=1, last=1, sub=imm=0.
// 2 Program bank0 ptr[64]={len 3, base 1}, data[1..4]=A,B,C,D; req 64 ->
//   (A,B,s0),(B,C,s1),(C,D,s2,last).
// 3 Same as 2 with out_ready low 5 cycles at step 1 -> (B,C,s1) held stable;
//   no skip, no duplicate.
// 4 Bank1 ptr[64]={2,10}, data 10..12 = E,F,G; key=8'h01 -> (E,F),(F,G); bank0 result unaffected.
// 5 ptr={2, base 126}, data[126]=X, [127]=Y, [0]=Z -> (X,Y),(Y,Z).
//   cfg_we during EMIT -> cfg_ready=0, table unchanged.
// 6 rst low at step 1 of a 3-step sequence -> IDLE, out_valid=0, req_ready=1; ptr[64] now bypasses.

Source files
------------

// File: rtl/obf_lut_seq.sv
// obf_lut_seq: banked substitution-sequence engine.
// A request (index, key) selects a bank and a pointer entry {len, base}; the
// engine then streams len (sub, imm) pairs read from the bank's data table.
// An invalid pointer entry or len==0 produces a single bypass pair.
// Both tables are written through the cfg port, which is only open in IDLE.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and its payload stable until that
// edge; ready may be low for any number of cycles and does not depend on
// valid on the same port. This applies to req_*, out_* and cfg_* (cfg_we
// plays the role of valid).
module obf_lut_seq #(
    parameter int IDX_W  = 7,
    parameter int ENT_W  = 16,
    parameter int ADDR_W = 7,
    parameter int LEN_W  = 4,
    parameter int BANK_W = 1,
    parameter int KEY_W  = 8,
    parameter int CFG_AW = (IDX_W > ADDR_W) ? IDX_W : ADDR_W,
    parameter int CFG_DW = (ENT_W > LEN_W + ADDR_W) ? ENT_W : LEN_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [IDX_W-1:0]  req_index,
    input  logic [KEY_W-1:0]  req_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ENT_W-1:0]  out_sub,
    output logic [ENT_W-1:0]  out_imm,
    output logic [LEN_W-1:0]  out_step,
    output logic              out_last,
    output logic              out_bypass,
    input  logic              cfg_we,
    output logic              cfg_ready,
    input  logic              cfg_sel,
    input  logic [BANK_W-1:0] cfg_bank,
    input  logic [CFG_AW-1:0] cfg_addr,
    input  logic [CFG_DW-1:0] cfg_wdata
);

    localparam int NB = 1 << BANK_W;
    localparam int PD = 1 << IDX_W;
    localparam int DD = 1 << ADDR_W;

    // LOOKUP registers the pointer entry, RESOLVE decides bypass vs. fetch.
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOOKUP  = 3'd1,
        S_RESOLVE = 3'd2,
        S_FETCH   = 3'd3,
        S_EMIT    = 3'd4
    } state_t;

    state_t state;
    state_t state_nx;

    // Tables: data and pointer payloads are plain storage, only valid bits reset.
    logic [ENT_W-1:0]  data_mem [NB][DD];
    logic [LEN_W-1:0]  ptr_len  [NB][PD];
    logic [ADDR_W-1:0] ptr_base [NB][PD];
    logic              ptr_vld  [NB][PD];

    logic [IDX_W-1:0]  idx_q;
    logic [BANK_W-1:0] bank_q;
    logic              pv_q;
    logic [LEN_W-1:0]  plen_q;
    logic [ADDR_W-1:0] pbase_q;
    logic [LEN_W-1:0]  step_q;
    logic [ENT_W-1:0]  sub_q;
    logic [ENT_W-1:0]  imm_q;
    logic              bypass_q;

    logic              cfg_fire;
    logic              ptr_bypass;
    logic              step_last;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic              unused_key;

    assign unused_key = ^req_key[KEY_W-1:BANK_W];
    assign cfg_fire   = cfg_we && cfg_ready;
    assign ptr_bypass = !pv_q || (plen_q == '0);
    assign step_last  = bypass_q || (step_q == LEN_W'(plen_q - LEN_W'(1)));
    // Data addresses wrap modulo the table depth.
    assign addr_a     = pbase_q + ADDR_W'(step_q);
    assign addr_b     = addr_a + ADDR_W'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:    if (req_valid) state_nx = S_LOOKUP;
            S_LOOKUP:  state_nx = S_RESOLVE;
            S_RESOLVE: state_nx = ptr_bypass ? S_EMIT : S_FETCH;
            S_FETCH:   state_nx = S_EMIT;
            S_EMIT:    if (out_ready) state_nx = step_last ? S_IDLE : S_FETCH;
            default:   state_nx = S_IDLE;
        endcase
    end

    // FSM-decoded outputs.
    always_comb begin
        req_ready = 1'b0;
        cfg_ready = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                cfg_ready = 1'b1;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                out_last  = step_last;
            end
            default: ;
        endcase
    end

    assign out_sub    = sub_q;
    assign out_imm    = imm_q;
    assign out_step   = step_q;
    assign out_bypass = bypass_q;

    // Datapath: request latch, pointer read, pair fetch, step advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q    <= '0;
            bank_q   <= '0;
            pv_q     <= 1'b0;
            plen_q   <= '0;
            pbase_q  <= '0;
            step_q   <= '0;
            sub_q    <= '0;
            imm_q    <= '0;
            bypass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        idx_q  <= req_index;
                        bank_q <= req_key[BANK_W-1:0];
                    end
                end
                S_LOOKUP: begin
                    pv_q    <= ptr_vld[bank_q][idx_q];
                    plen_q  <= ptr_len[bank_q][idx_q];
                    pbase_q <= ptr_base[bank_q][idx_q];
                end
                S_RESOLVE: begin
                    step_q   <= '0;
                    bypass_q <= ptr_bypass;
                    if (ptr_bypass) begin
                        sub_q <= '0;
                        imm_q <= '0;
                    end
                end
                S_FETCH: begin
                    sub_q <= data_mem[bank_q][addr_a];
                    imm_q <= data_mem[bank_q][addr_b];
                end
                S_EMIT: begin
                    if (out_ready && !step_last) step_q <= step_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Table payload writes; a write and a request accept on the same edge
    // both land before the pointer read in LOOKUP.
    always_ff @(posedge clk) begin
        if (rst && cfg_fire) begin
            if (cfg_sel) begin
                ptr_len[cfg_bank][cfg_addr[IDX_W-1:0]]  <= cfg_wdata[LEN_W+ADDR_W-1:ADDR_W];
                ptr_base[cfg_bank][cfg_addr[IDX_W-1:0]] <= cfg_wdata[ADDR_W-1:0];
            end else begin
                data_mem[cfg_bank][cfg_addr[ADDR_W-1:0]] <= cfg_wdata[ENT_W-1:0];
            end
        end
    end

    // Pointer valid bits: cleared by reset, set by pointer writes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int b = 0; b < NB; b++)
                for (int i = 0; i < PD; i++)
                    ptr_vld[b][i] <= 1'b0;
        end else if (cfg_fire && cfg_sel) begin
            ptr_vld[cfg_bank][cfg_addr[IDX_W-1:0]] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_obf_lut_seq.sv
// tb_obf_lut_seq: directed bench for obf_lut_seq with a table-level reference
// model, an expected-pair queue checked every cycle out_valid is high, and
// literal checks on the captured pairs.
module tb_obf_lut_seq;

  localparam int IDX_W  = 7;
  localparam int ENT_W  = 16;
  localparam int ADDR_W = 7;
  localparam int LEN_W  = 4;
  localparam int BANK_W = 1;
  localparam int KEY_W  = 8;
  localparam int DD     = 128;
  localparam int PD     = 128;

  typedef struct packed {
    logic [ENT_W-1:0] sub;
    logic [ENT_W-1:0] imm;
    logic [LEN_W-1:0] step;
    logic             last;
    logic             byp;
  } pair_t;
  localparam int PW = $bits(pair_t);

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [IDX_W-1:0]  req_index;
  logic [KEY_W-1:0]  req_key;
  logic              out_valid;
  logic              out_ready;
  logic [ENT_W-1:0]  out_sub;
  logic [ENT_W-1:0]  out_imm;
  logic [LEN_W-1:0]  out_step;
  logic              out_last;
  logic              out_bypass;
  logic              cfg_we;
  logic              cfg_ready;
  logic              cfg_sel;
  logic [BANK_W-1:0] cfg_bank;
  logic [6:0]        cfg_addr;
  logic [15:0]       cfg_wdata;

  obf_lut_seq dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_key(req_key),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sub(out_sub), .out_imm(out_imm), .out_step(out_step),
    .out_last(out_last), .out_bypass(out_bypass),
    .cfg_we(cfg_we), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_bank(cfg_bank), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata)
  );

  // reference model of the tables
  logic [ENT_W-1:0]  m_data [2][DD];
  logic [LEN_W-1:0]  m_len  [2][PD];
  logic [ADDR_W-1:0] m_base [2][PD];
  logic              m_vld  [2][PD];

  // scoreboard
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] got_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  pair_t cmp_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // every cycle a pair is offered, it must equal the head of the expected queue
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 64'(out_valid), 64'd0);
      end else begin
        cmp_e = pair_t'(exp_q[0]);
        check("out_sub",    64'(out_sub),    64'(cmp_e.sub));
        check("out_imm",    64'(out_imm),    64'(cmp_e.imm));
        check("out_step",   64'(out_step),   64'(cmp_e.step));
        check("out_last",   64'(out_last),   64'(cmp_e.last));
        check("out_bypass", 64'(out_bypass), 64'(cmp_e.byp));
        if (out_ready && rst) begin
          got_q.push_back({out_sub, out_imm, out_step, out_last, out_bypass});
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // model: the whole sequence a request must produce
  task automatic push_expected(input int b, input int idx);
    int base, len, a;
    pair_t p;
    len  = int'(m_len[b][idx]);
    base = int'(m_base[b][idx]);
    if (!m_vld[b][idx] || len == 0) begin
      p = '{sub: '0, imm: '0, step: '0, last: 1'b1, byp: 1'b1};
      exp_q.push_back(PW'(p));
    end else begin
      for (int s = 0; s < len; s++) begin
        a = (base + s) % DD;
        p.sub  = m_data[b][a];
        p.imm  = m_data[b][(a + 1) % DD];
        p.step = LEN_W'(s);
        p.last = (s == len - 1);
        p.byp  = 1'b0;
        exp_q.push_back(PW'(p));
      end
    end
  endtask

  task automatic model_write(input logic sel, input int b, input int addr, input logic [15:0] wd);
    if (sel) begin
      m_len[b][addr]  = wd[10:7];
      m_base[b][addr] = wd[6:0];
      m_vld[b][addr]  = 1'b1;
    end else begin
      m_data[b][addr] = wd;
    end
  endtask

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic cfg_write(input logic sel, input int b, input int addr, input logic [15:0] wd);
    int k;
    cfg_we = 1'b1; cfg_sel = sel; cfg_bank = BANK_W'(b); cfg_addr = 7'(addr); cfg_wdata = wd;
    k = 0;
    while (!cfg_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) check("cfg_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    model_write(sel, b, addr, wd);
    #1 cfg_we = 1'b0;
  endtask

  task automatic do_req(input int idx, input logic [7:0] key, output int lat);
    int k;
    req_valid = 1'b1; req_index = IDX_W'(idx); req_key = key;
    k = 0;
    while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
    if (k >= 50) check("req_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    push_expected(int'(key[0]), idx);
    #1 req_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || !req_ready) && k < 200) begin @(posedge clk); #1; k++; end
    check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_step(input string name, input int step);
    int k;
    k = 0;
    while (!(out_valid && out_step == LEN_W'(step)) && k < 50) begin @(posedge clk); #1; k++; end
    check({name, "_reach_step"}, 64'(k < 50), 64'd1);
  endtask

  task automatic check_got(input string name, input int i, input logic [15:0] s,
                           input logic [15:0] im, input int st, input logic l, input logic bp);
    pair_t g;
    if (got_q.size() <= i) begin
      check({name, "_missing"}, 64'(got_q.size()), 64'(i + 1));
    end else begin
      g = pair_t'(got_q[i]);
      check({name, "_lit"}, 64'({g.sub, g.imm, g.step, g.last, g.byp}),
            64'({s, im, LEN_W'(st), l, bp}));
    end
  endtask

  localparam logic [15:0] VA = 16'hA1A1, VB = 16'hB2B2, VC = 16'hC3C3, VD = 16'hD4D4;
  localparam logic [15:0] VE = 16'hE5E5, VF = 16'hF6F6, VG = 16'h1717;
  localparam logic [15:0] VX = 16'h5A5A, VY = 16'h6B6B, VZ = 16'h7C7C;

  initial begin
    int lat;
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < PD; i++) begin
        m_vld[b][i] = 1'b0; m_len[b][i] = '0; m_base[b][i] = '0; m_data[b][i] = '0;
      end
    rst = 1'b0; req_valid = 1'b0; req_index = '0; req_key = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_sel = 1'b0; cfg_bank = '0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_out_last",   64'(out_last),   64'd0);
    check("rst_out_bypass", 64'(out_bypass), 64'd0);
    check("rst_out_step",   64'(out_step),   64'd0);
    check("rst_out_subimm", 64'({out_sub, out_imm}), 64'd0);
    check("rst_req_ready",  64'(req_ready),  64'd1);
    check("rst_cfg_ready",  64'(cfg_ready),  64'd1);
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: unprogrammed entry bypasses, two cycles after accept
    got_q.delete();
    do_req(64, 8'h00, lat);
    check("t1_latency", 64'(lat), 64'd2);
    wait_done("t1");
    check_got("t1_pair", 0, 16'h0, 16'h0, 0, 1'b1, 1'b1);

    // 2: three-pair sequence from bank 0
    cfg_write(1'b0, 0, 1, VA);
    cfg_write(1'b0, 0, 2, VB);
    cfg_write(1'b0, 0, 3, VC);
    cfg_write(1'b0, 0, 4, VD);
    cfg_write(1'b1, 0, 64, {5'd0, 4'd3, 7'd1});
    got_q.delete();
    do_req(64, 8'h00, lat);
    check("t2_latency", 64'(lat), 64'd3);
    wait_done("t2");
    check("t2_count", 64'(got_q.size()), 64'd3);
    check_got("t2_p0", 0, VA, VB, 0, 1'b0, 1'b0);
    check_got("t2_p1", 1, VB, VC, 1, 1'b0, 1'b0);
    check_got("t2_p2", 2, VC, VD, 2, 1'b1, 1'b0);

    // 3: consumer stalls for 5 cycles on step 1
    got_q.delete();
    do_req(64, 8'h00, lat);
    wait_step("t3", 1);
    out_ready = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      check("t3_hold_valid", 64'(out_valid), 64'd1);
      check("t3_hold_pair",  64'({out_sub, out_imm, out_step}), 64'({VB, VC, 4'd1}));
    end
    out_ready = 1'b1;
    wait_done("t3");
    check("t3_count", 64'(got_q.size()), 64'd3);
    check_got("t3_p1", 1, VB, VC, 1, 1'b0, 1'b0);
    check_got("t3_p2", 2, VC, VD, 2, 1'b1, 1'b0);

    // 4: bank 1 entry, bank 0 unaffected (key 8'h02 selects bank 0)
    cfg_write(1'b0, 1, 10, VE);
    cfg_write(1'b0, 1, 11, VF);
    cfg_write(1'b0, 1, 12, VG);
    cfg_write(1'b1, 1, 64, {5'd0, 4'd2, 7'd10});
    got_q.delete();
    do_req(64, 8'h01, lat);
    wait_done("t4a");
    check("t4a_count", 64'(got_q.size()), 64'd2);
    check_got("t4a_p0", 0, VE, VF, 0, 1'b0, 1'b0);
    check_got("t4a_p1", 1, VF, VG, 1, 1'b1, 1'b0);
    got_q.delete();
    do_req(64, 8'h02, lat);
    wait_done("t4b");
    check("t4b_count", 64'(got_q.size()), 64'd3);
    check_got("t4b_p0", 0, VA, VB, 0, 1'b0, 1'b0);

    // 5: address wrap, and a cfg write attempted during EMIT is refused
    cfg_write(1'b0, 0, 126, VX);
    cfg_write(1'b0, 0, 127, VY);
    cfg_write(1'b0, 0, 0, VZ);
    cfg_write(1'b1, 0, 5, {5'd0, 4'd2, 7'd126});
    got_q.delete();
    do_req(5, 8'h00, lat);
    out_ready = 1'b0;
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_bank = 1'b0; cfg_addr = 7'd5; cfg_wdata = {5'd0, 4'd1, 7'd0};
    check("t5_cfg_ready_emit", 64'(cfg_ready), 64'd0);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    out_ready = 1'b1;
    wait_done("t5a");
    check_got("t5a_p0", 0, VX, VY, 0, 1'b0, 1'b0);
    check_got("t5a_p1", 1, VY, VZ, 1, 1'b1, 1'b0);
    got_q.delete();
    do_req(5, 8'h00, lat);
    wait_done("t5b");
    check("t5b_count", 64'(got_q.size()), 64'd2);
    check_got("t5b_p1", 1, VY, VZ, 1, 1'b1, 1'b0);

    // len 0 entry bypasses
    cfg_write(1'b1, 0, 7, {5'd0, 4'd0, 7'd5});
    got_q.delete();
    do_req(7, 8'h00, lat);
    check("t7_len0_latency", 64'(lat), 64'd2);
    wait_done("t7");
    check_got("t7_pair", 0, 16'h0, 16'h0, 0, 1'b1, 1'b1);

    // write and request accepted on the same edge: lookup sees the new entry
    cfg_write(1'b0, 0, 20, 16'h1111);
    cfg_write(1'b0, 0, 21, 16'h2222);
    got_q.delete();
    cfg_we = 1'b1; cfg_sel = 1'b1; cfg_bank = 1'b0; cfg_addr = 7'd3; cfg_wdata = {5'd0, 4'd1, 7'd20};
    req_valid = 1'b1; req_index = 7'd3; req_key = 8'h00;
    check("t8_both_ready", 64'({cfg_ready, req_ready}), 64'd3);
    @(posedge clk);
    model_write(1'b1, 0, 3, {5'd0, 4'd1, 7'd20});
    push_expected(0, 3);
    #1 cfg_we = 1'b0; req_valid = 1'b0;
    wait_done("t8");
    check_got("t8_pair", 0, 16'h1111, 16'h2222, 0, 1'b1, 1'b0);

    // 6: reset at step 1 aborts the sequence and invalidates pointers
    got_q.delete();
    do_req(64, 8'h00, lat);
    wait_step("t6", 1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("t6_out_valid", 64'(out_valid), 64'd0);
    check("t6_req_ready", 64'(req_ready), 64'd1);
    exp_q.delete();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < PD; i++) m_vld[b][i] = 1'b0;
    rst = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("t6_idle_quiet", 64'(out_valid), 64'd0);
    end
    check("t6_got_before_reset", 64'(got_q.size()), 64'd1);
    got_q.delete();
    do_req(64, 8'h00, lat);
    wait_done("t6");
    check("t6_count", 64'(got_q.size()), 64'd1);
    check_got("t6_pair", 0, 16'h0, 16'h0, 0, 1'b1, 1'b1);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
